// File: rtl/cdb_arbiter.sv
// Round-robin write-back arbiter: up to CDB_WIDTH of PORT_COUNT result FIFOs onto a registered CDB.
// Optional per-port grant/stall counters are built when CDB_ARB_PERF_CNT_EN is defined.
module cdb_arbiter #(
  parameter int unsigned PORT_COUNT = 4,
  parameter int unsigned CDB_WIDTH  = 2,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned PTR_W      = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [PORT_COUNT-1:0]        fifo_valid_i,
  output logic [PORT_COUNT-1:0]        fifo_ready_o,
  input  logic [PORT_COUNT*DATA_W-1:0] fifo_data_i,
  output logic [CDB_WIDTH-1:0]         cdb_valid_o,
  output logic [CDB_WIDTH*DATA_W-1:0]  cdb_data_o,
  output logic [CDB_WIDTH*PTR_W-1:0]   cdb_port_o
`ifdef CDB_ARB_PERF_CNT_EN
  ,
  output logic [PORT_COUNT*32-1:0]     perf_grant_cnt_o,
  output logic [PORT_COUNT*32-1:0]     perf_stall_cnt_o
`endif
);

  logic [PORT_COUNT-1:0]        grant;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CDB_WIDTH-1:0]         cdb_valid_q, cdb_valid_d;
  logic [CDB_WIDTH*DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [CDB_WIDTH*PTR_W-1:0]   cdb_port_q, cdb_port_d;
  int unsigned                  scan_idx;
  int unsigned                  scan_n;

  // Pops are suppressed during flush and while reset is held.
  assign fifo_ready_o = grant & {PORT_COUNT{rst_n & ~flush_i}};

  always_comb begin
    grant       = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = '0;
    cdb_data_d  = cdb_data_q;
    cdb_port_d  = cdb_port_q;
    scan_idx    = 0;
    scan_n      = 0;
    for (int unsigned k = 0; k < PORT_COUNT; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % PORT_COUNT;
      if (fifo_valid_i[scan_idx] && (scan_n < CDB_WIDTH)) begin
        grant[scan_idx]                          = 1'b1;
        cdb_valid_d[scan_n]                      = 1'b1;
        cdb_data_d[scan_n*DATA_W +: DATA_W]      = fifo_data_i[scan_idx*DATA_W +: DATA_W];
        cdb_port_d[scan_n*PTR_W +: PTR_W]        = PTR_W'(scan_idx);
        rr_ptr_d                                 = PTR_W'((scan_idx + 1) % PORT_COUNT);
        scan_n                                   = scan_n + 1;
      end
    end
    if (flush_i) begin
      cdb_valid_d = '0;
      cdb_data_d  = cdb_data_q;
      cdb_port_d  = cdb_port_q;
      rr_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_data_q  <= '0;
      cdb_port_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_port_q  <= cdb_port_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_port_o  = cdb_port_q;

`ifdef CDB_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [PORT_COUNT];
  logic [31:0] stall_cnt_q [PORT_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
        grant_cnt_q[p] <= '0;
        stall_cnt_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < PORT_COUNT; p++) begin
        if (fifo_valid_i[p] && fifo_ready_o[p]) begin
          grant_cnt_q[p] <= grant_cnt_q[p] + 32'd1;
        end else if (fifo_valid_i[p] && !flush_i) begin
          stall_cnt_q[p] <= stall_cnt_q[p] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_grant_cnt_o = '0;
    perf_stall_cnt_o = '0;
    for (int unsigned p = 0; p < PORT_COUNT; p++) begin
      perf_grant_cnt_o[p*32 +: 32] = grant_cnt_q[p];
      perf_stall_cnt_o[p*32 +: 32] = stall_cnt_q[p];
    end
  end
`endif

endmodule
